// File: rtl/sram_bus_bridge.sv
// SRAM-style inst/data ports to a shared single-outstanding req/addr_ok/data_ok bus.
// Holds the pipeline until every enabled access of the current step has completed.
module sram_bus_bridge #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_stall,
    input  logic        inst_sram_en,
    input  logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       inst_done;
    logic       data_done;
    logic       cur_is_data;
    logic       inst_pend;
    logic       data_pend;
    logic       pick_data;
    logic       step_done;
    logic [1:0] wsize;

    assign inst_pend = inst_sram_en & ~inst_done;
    assign data_pend = data_sram_en & ~data_done;
    assign stallreq  = inst_pend | data_pend;
    assign pick_data = data_pend & (~inst_pend | DATA_FIRST);
    assign step_done = (state == IDLE) & ~stallreq & ~pipe_stall;

    // Store size follows the strobe pattern; only aligned patterns are legal.
    always_comb begin
        wsize = 2'd0;
        case (data_sram_wen)
            4'b1111:          wsize = 2'd2;
            4'b0011, 4'b1100: wsize = 2'd1;
            default:          wsize = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            inst_done       <= 1'b0;
            data_done       <= 1'b0;
            cur_is_data     <= 1'b0;
            bus_req         <= 1'b0;
            bus_wr          <= 1'b0;
            bus_size        <= 2'd0;
            bus_wstrb       <= 4'd0;
            bus_addr        <= 32'd0;
            bus_wdata       <= 32'd0;
            inst_sram_rdata <= 32'd0;
            data_sram_rdata <= 32'd0;
        end else begin
            if (step_done) begin
                inst_done <= 1'b0;
                data_done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (inst_pend | data_pend) begin
                        state       <= REQ;
                        bus_req     <= 1'b1;
                        cur_is_data <= pick_data;
                        if (pick_data) begin
                            bus_wr    <= |data_sram_wen;
                            bus_size  <= (|data_sram_wen) ? wsize : 2'd2;
                            bus_wstrb <= data_sram_wen;
                            bus_addr  <= data_sram_addr;
                            bus_wdata <= data_sram_wdata;
                        end else begin
                            bus_wr    <= 1'b0;
                            bus_size  <= 2'd2;
                            bus_wstrb <= 4'd0;
                            bus_addr  <= inst_sram_addr;
                            bus_wdata <= 32'd0;
                        end
                    end
                end
                REQ: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (bus_data_ok) begin
                        state <= IDLE;
                        if (cur_is_data) begin
                            data_done <= 1'b1;
                            if (!bus_wr) begin
                                data_sram_rdata <= bus_rdata;
                            end
                        end else begin
                            inst_done       <= 1'b1;
                            inst_sram_rdata <= bus_rdata;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Randomized bench for sram_bus_bridge: a delay-programmable bus slave plus a
// step-level model of the expected bus transactions, stall length and rdata.
module tb_sram_bus_bridge;

    localparam bit DATA_FIRST = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_stall;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    sram_bus_bridge #(.DATA_FIRST(DATA_FIRST)) dut (
        .clk             (clk),
        .rst             (rst),
        .pipe_stall      (pipe_stall),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .stallreq        (stallreq),
        .bus_req         (bus_req),
        .bus_wr          (bus_wr),
        .bus_size        (bus_size),
        .bus_wstrb       (bus_wstrb),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_addr_ok     (bus_addr_ok),
        .bus_data_ok     (bus_data_ok),
        .bus_rdata       (bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    txn_t        req_log[$];
    logic [31:0] rsp_log[$];
    logic [31:0] fixed_q[$];

    int          addr_dly = 0;
    int          data_dly = 0;
    bit          slave_off = 1'b0;
    bit          in_req = 1'b0;
    bit          resp_pend = 1'b0;
    int          acnt = 0;
    int          dcnt = 0;
    logic [31:0] resp_data;
    logic [31:0] held_addr;
    int          req_cycles = 0;
    int          unstable = 0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_inst = 32'd0;
    logic [31:0] exp_data = 32'd0;
    int          last_stall = 0;

    // Bus slave: accepts after addr_dly extra cycles, responds data_dly later.
    always @(negedge clk) begin
        if (!slave_off) begin
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            if (rst) begin
                in_req    = 1'b0;
                resp_pend = 1'b0;
            end else begin
                if (bus_req) req_cycles++;
                if (resp_pend) begin
                    if (dcnt == 0) begin
                        bus_data_ok = 1'b1;
                        bus_rdata   = resp_data;
                        resp_pend   = 1'b0;
                    end else begin
                        dcnt--;
                    end
                end else if (bus_req) begin
                    if (!in_req) begin
                        in_req    = 1'b1;
                        acnt      = addr_dly;
                        held_addr = bus_addr;
                    end else if (bus_addr != held_addr) begin
                        unstable++;
                    end
                    if (acnt == 0) begin
                        bus_addr_ok = 1'b1;
                        in_req      = 1'b0;
                        resp_pend   = 1'b1;
                        dcnt        = data_dly;
                        if (fixed_q.size() > 0) resp_data = fixed_q.pop_front();
                        else resp_data = $urandom;
                        req_log.push_back(txn_t'{bus_addr, bus_wr, bus_size,
                                                 bus_wstrb, bus_wdata});
                        rsp_log.push_back(resp_data);
                    end else begin
                        acnt--;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] size_of(input logic [3:0] wen);
        int n;
        n = $countones(wen);
        if (n == 0 || n == 4) return 2'd2;
        if (n == 2) return 2'd1;
        return 2'd0;
    endfunction

    // One pipeline step: present the accesses, wait for release, check results.
    task automatic run_step(input bit ie, input logic [31:0] ia, input bit de,
                            input logic [3:0] dw, input logic [31:0] da,
                            input logic [31:0] dd, input int ps);
        txn_t exp_q[$];
        bit   is_d[$];
        txn_t ti;
        txn_t td;
        int   n;
        ti = txn_t'{ia, 1'b0, 2'd2, 4'd0, 32'd0};
        td = txn_t'{da, (dw != 4'd0), size_of(dw), dw, dd};
        if (ie && de && DATA_FIRST) begin
            exp_q.push_back(td); is_d.push_back(1'b1);
            exp_q.push_back(ti); is_d.push_back(1'b0);
        end else begin
            if (ie) begin exp_q.push_back(ti); is_d.push_back(1'b0); end
            if (de) begin exp_q.push_back(td); is_d.push_back(1'b1); end
        end
        req_log.delete();
        rsp_log.delete();
        req_cycles = 0;
        unstable   = 0;
        inst_sram_en    = ie;
        inst_sram_addr  = ia;
        data_sram_en    = de;
        data_sram_wen   = dw;
        data_sram_addr  = da;
        data_sram_wdata = dd;
        #1;
        check("stall_start", 32'(stallreq), 32'(ie | de));
        n = 0;
        while (stallreq && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("stall_timeout", 32'(stallreq), 32'd0);
        last_stall = n;
        if (ps > 0) begin
            pipe_stall = 1'b1;
            repeat (ps) begin
                @(negedge clk);
                check("ps_stallreq", 32'(stallreq), 32'd0);
            end
            pipe_stall = 1'b0;
        end
        check("req_count", 32'(req_log.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < req_log.size()) begin
                check("txn_addr", req_log[k].addr, exp_q[k].addr);
                check("txn_wr", 32'(req_log[k].wr), 32'(exp_q[k].wr));
                check("txn_size", 32'(req_log[k].size), 32'(exp_q[k].size));
                check("txn_wstrb", 32'(req_log[k].wstrb), 32'(exp_q[k].wstrb));
                if (exp_q[k].wr) check("txn_wdata", req_log[k].wdata, exp_q[k].wdata);
                if (!is_d[k]) exp_inst = rsp_log[k];
                else if (!exp_q[k].wr) exp_data = rsp_log[k];
            end
        end
        if (ie | de)
            check("stall_cycles", 32'(n),
                  32'(exp_q.size() * (3 + addr_dly + data_dly)));
        check("addr_stable", 32'(unstable), 32'd0);
        check("inst_rdata", inst_sram_rdata, exp_inst);
        check("data_rdata", data_sram_rdata, exp_data);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] wen_tab [9];
        wen_tab = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
        rst = 1'b1;
        pipe_stall = 1'b0;
        inst_sram_en = 1'b0;
        inst_sram_addr = 32'd0;
        data_sram_en = 1'b0;
        data_sram_wen = 4'd0;
        data_sram_addr = 32'd0;
        data_sram_wdata = 32'd0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_inst_rdata", inst_sram_rdata, 32'd0);
        check("rst_data_rdata", data_sram_rdata, 32'd0);
        check("rst_stallreq", 32'(stallreq), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        fixed_q = '{32'h3C1D0001};
        run_step(1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, 0);
        check("fetch_req_cycles", 32'(req_cycles), 32'd1);
        check("fetch_stall", 32'(last_stall), 32'd3);
        check("fetch_rdata", inst_sram_rdata, 32'h3C1D0001);

        fixed_q = '{32'hDEADBEEF, 32'h00000001};
        run_step(1'b1, 32'h100, 1'b1, 4'h0, 32'h2000, 32'h0, 0);
        if (req_log.size() == 2) begin
            check("both_first_addr", req_log[0].addr, 32'h2000);
            check("both_second_addr", req_log[1].addr, 32'h100);
        end else begin
            check("both_count", 32'(req_log.size()), 32'd2);
        end
        check("both_data_rdata", data_sram_rdata, 32'hDEADBEEF);
        check("both_inst_rdata", inst_sram_rdata, 32'h00000001);

        run_step(1'b0, 32'h0, 1'b1, 4'b0100, 32'h3002, 32'h00AB0000, 0);
        check("store_keep_rdata", data_sram_rdata, 32'hDEADBEEF);

        addr_dly = 4;
        run_step(1'b1, 32'h200, 1'b0, 4'h0, 32'h0, 32'h0, 0);
        check("slow_req_cycles", 32'(req_cycles), 32'd5);
        check("slow_one_req", 32'(req_log.size()), 32'd1);
        addr_dly = 0;

        run_step(1'b1, 32'h300, 1'b1, 4'h0, 32'h4000, 32'h0, 2);
        run_step(1'b1, 32'h304, 1'b0, 4'h0, 32'h0, 32'h0, 0);

        data_dly = 5;
        inst_sram_en = 1'b1;
        inst_sram_addr = 32'h500;
        repeat (2) @(negedge clk);
        slave_off = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_bus_req", 32'(bus_req), 32'd0);
        check("arst_bus_addr", bus_addr, 32'd0);
        check("arst_inst_rdata", inst_sram_rdata, 32'd0);
        check("arst_data_rdata", data_sram_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        inst_sram_en = 1'b0;
        in_req = 1'b0;
        resp_pend = 1'b0;
        data_dly = 0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata = 32'h12345678;
        @(negedge clk);
        bus_data_ok = 1'b0;
        check("late_dok_inst", inst_sram_rdata, 32'd0);
        check("late_dok_req", 32'(bus_req), 32'd0);
        check("late_dok_stall", 32'(stallreq), 32'd0);
        slave_off = 1'b0;
        exp_inst = 32'd0;
        exp_data = 32'd0;
        @(negedge clk);
        run_step(1'b1, 32'h600, 1'b0, 4'h0, 32'h0, 32'h0, 0);

        for (int i = 0; i < 150; i++) begin
            addr_dly = $urandom_range(0, 3);
            data_dly = $urandom_range(0, 3);
            run_step(1'($urandom_range(0, 1)), $urandom,
                     1'($urandom_range(0, 1)), wen_tab[$urandom_range(0, 8)],
                     $urandom, $urandom, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
